sm_timer: RTL and testbench

SM_TIMER -- requirements
Module: sm_timer

---
 rtl/sm_timer.sv | 169 ++++++++++++++++
 tb/tb_sm_timer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_timer.sv
// -----------------------------------------------------------------------------
// sm_timer -- programmable sample delay line built on a ring buffer.
//
// Every tick the incoming sample din is written into a MAX_DELAY-entry ring
// buffer. Once the pipeline has been refilled after reset or after a delay
// change, dout presents the sample written dly_cur-1 ticks before the current
// edge. The delay takes effect on the edge that loads it, so dout shows each
// sample dly_cur edges after it arrives. dout_valid tells downstream logic
// when dout is a genuine delayed sample.
//
// Parameters:
//   WIDTH       data lane width in bits
//   MAX_DELAY   largest programmable delay in ticks (40 ticks = 1 s game time)
//   RESET_DELAY delay in force after reset, 1..MAX_DELAY
//
// Ports:
//   clk        in   tick clock, rising edge active
//   rst_n      in   asynchronous reset, active low
//   din        in   sample captured every tick
//   dly_wr     in   load dly_val as the new delay (restarts the fill)
//   dly_val    in   requested delay in ticks, clamped to 1..MAX_DELAY
//   flush      in   empty the pipeline, keeping the delay
//                   (only present when SM_TIMER_FLUSH_EN is defined)
//   dly_cur    out  delay currently in force
//   dout       out  din delayed by dly_cur ticks, zero while not valid
//   dout_valid out  dout holds a genuine delayed sample
//
// Optional feature macro: SM_TIMER_FLUSH_EN adds the flush input.
// -----------------------------------------------------------------------------
module sm_timer #(
  parameter int WIDTH       = 8,
  parameter int MAX_DELAY   = 64,
  parameter int RESET_DELAY = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WIDTH-1:0]               din,
  input  logic                           dly_wr,
  input  logic [$clog2(MAX_DELAY+1)-1:0] dly_val,
`ifdef SM_TIMER_FLUSH_EN
  input  logic                           flush,
`endif
  output logic [$clog2(MAX_DELAY+1)-1:0] dly_cur,
  output logic [WIDTH-1:0]               dout,
  output logic                           dout_valid
);

  localparam int DW = $clog2(MAX_DELAY + 1);
  localparam int PW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  logic [DW-1:0]      fill_cnt;
  logic [PW-1:0]      wr_ptr;
  logic [WIDTH-1:0]   mem [MAX_DELAY];

  logic [DW-1:0]      dly_clamped;
  logic [DW-1:0]      back;
  logic [DW-1:0]      wr_ext;
  logic [DW-1:0]      rd_ext;
  logic [PW-1:0]      rd_ptr;
  logic [WIDTH-1:0]   sample;
  logic               flush_req;

`ifdef SM_TIMER_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Clamp the requested delay into the legal 1..MAX_DELAY window.
  always_comb begin
    dly_clamped = dly_val;
    if (dly_val == '0) begin
      dly_clamped = DW'(1);
    end else if (dly_val > DW'(MAX_DELAY)) begin
      dly_clamped = DW'(MAX_DELAY);
    end
  end

  // Read address: the entry written dly_cur-1 ticks ago, i.e. wr_ptr minus
  // (dly_cur-1) modulo MAX_DELAY. With dly_cur = MAX_DELAY this lands on
  // wr_ptr+1, the oldest entry, which is read before this edge overwrites
  // the slot it will be reused for. A delay of one means "this edge's din",
  // which is not in the buffer yet, so it bypasses the storage entirely.
  always_comb begin
    back   = dly_cur - DW'(1);
    wr_ext = DW'(wr_ptr);
    if (wr_ext >= back) begin
      rd_ext = wr_ext - back;
    end else begin
      rd_ext = wr_ext + DW'(MAX_DELAY) - back;
    end
    rd_ptr = PW'(rd_ext);
    sample = (dly_cur == DW'(1)) ? din : mem[rd_ptr];
  end

  // Sample storage. Deliberately not reset: anything stale is hidden by the
  // FILL phase, which never exposes an entry written before the fill began.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      mem[wr_ptr] <= din;
    end
  end

  // Control FSM plus registered outputs. A delay load beats a flush; either
  // one restarts the fill and blanks the output on the same edge. In FILL
  // the counter tracks how many samples of the new pipeline have arrived,
  // and the edge that brings in sample number dly_cur switches to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      fill_cnt   <= '0;
      wr_ptr     <= '0;
      dly_cur    <= DW'(RESET_DELAY);
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (wr_ptr == PW'(MAX_DELAY - 1)) begin
        wr_ptr <= '0;
      end else begin
        wr_ptr <= wr_ptr + PW'(1);
      end

      if (dly_wr) begin
        dly_cur    <= dly_clamped;
        state      <= FILL;
        fill_cnt   <= '0;
        dout       <= '0;
        dout_valid <= 1'b0;
      end else if (flush_req) begin
        state      <= FILL;
        fill_cnt   <= '0;
        dout       <= '0;
        dout_valid <= 1'b0;
      end else begin
        case (state)
          FILL: begin
            if (fill_cnt + DW'(1) == dly_cur) begin
              state      <= RUN;
              fill_cnt   <= '0;
              dout       <= sample;
              dout_valid <= 1'b1;
            end else begin
              fill_cnt   <= fill_cnt + DW'(1);
              dout       <= '0;
              dout_valid <= 1'b0;
            end
          end
          RUN: begin
            dout       <= sample;
            dout_valid <= 1'b1;
          end
          default: begin
            state      <= FILL;
            fill_cnt   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sm_timer.sv
// -----------------------------------------------------------------------------
// tb_sm_timer -- scoreboard bench for sm_timer.
//
// Each tick the stimulus task drives the inputs, runs a behavioural model
// (full din history indexed by absolute edge number, fill counter, clamp)
// and pushes the expected outputs for the coming edge onto a queue. Just
// after the edge the entry is popped and compared with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_sm_timer;

  localparam int WIDTH       = 8;
  localparam int MAX_DELAY   = 64;
  localparam int RESET_DELAY = 1;
  localparam int DW          = $clog2(MAX_DELAY + 1);
  localparam int HIST        = 4096;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             dly_wr;
  logic [DW-1:0]    dly_val;
  logic [DW-1:0]    dly_cur;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
`ifdef SM_TIMER_FLUSH_EN
  logic             flush;
`endif

  typedef struct {
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic [DW-1:0]    cur;
  } exp_t;

  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state.
  int               mCur   = RESET_DELAY;
  int               mCnt   = 0;
  bit               mValid = 1'b0;
  int               edgeN  = 0;
  logic [WIDTH-1:0] hist [HIST];

  sm_timer #(
    .WIDTH      (WIDTH),
    .MAX_DELAY  (MAX_DELAY),
    .RESET_DELAY(RESET_DELAY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .dly_wr    (dly_wr),
    .dly_val   (dly_val),
`ifdef SM_TIMER_FLUSH_EN
    .flush     (flush),
`endif
    .dly_cur   (dly_cur),
    .dout      (dout),
    .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts the vector and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  // Pop the oldest expectation and compare it with the current outputs.
  task automatic compareNext(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, ".dout"},    32'(dout),       32'(e.dout));
      checkOutput({tag, ".valid"},   32'(dout_valid), 32'(e.valid));
      checkOutput({tag, ".dly_cur"}, 32'(dly_cur),    32'(e.cur));
    end
  endtask

  // Drive one tick of stimulus, predict the result, then check it.
  task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] d,
                               input logic wr, input int val, input logic fl);
    exp_t e;
    din     = d;
    dly_wr  = wr;
    dly_val = DW'(val);
`ifdef SM_TIMER_FLUSH_EN
    flush   = fl;
`endif

    if (wr) begin
      mCur   = (val == 0) ? 1 : ((val > MAX_DELAY) ? MAX_DELAY : val);
      mCnt   = 0;
      mValid = 1'b0;
`ifdef SM_TIMER_FLUSH_EN
    end else if (fl) begin
      mCnt   = 0;
      mValid = 1'b0;
`endif
    end else if (!mValid) begin
      mCnt++;
      if (mCnt == mCur) mValid = 1'b1;
    end
    hist[edgeN] = d;
    e.valid = mValid;
    e.cur   = DW'(mCur);
    e.dout  = mValid ? hist[edgeN - mCur + 1] : '0;
    sb.push_back(e);
    edgeN++;

    @(posedge clk);
    #1;
    compareNext(tag);
    dly_wr = 1'b0;
`ifdef SM_TIMER_FLUSH_EN
    flush  = 1'b0;
`endif
  endtask

  task automatic modelReset();
    mCur   = RESET_DELAY;
    mCnt   = 0;
    mValid = 1'b0;
  endtask

  logic [WIDTH-1:0] seq = 8'h01;

  initial begin
    rst_n   = 1'b0;
    din     = '0;
    dly_wr  = 1'b0;
    dly_val = '0;
`ifdef SM_TIMER_FLUSH_EN
    flush   = 1'b0;
`endif

    // Reset state while reset is held.
    #7;
    checkOutput("rst.dout",    32'(dout),       32'd0);
    checkOutput("rst.valid",   32'(dout_valid), 32'd0);
    checkOutput("rst.dly_cur", 32'(dly_cur),    32'(RESET_DELAY));
    #5;
    rst_n = 1'b1;

    // Default delay: counting pattern straight through.
    for (int i = 0; i < 6; i++) begin
      applyStimulus("count", seq, 1'b0, 0, 1'b0);
      seq++;
    end

    // Load delay 5 while running, then watch the refill.
    applyStimulus("load5", seq, 1'b1, 5, 1'b0);
    seq++;
    for (int i = 0; i < 8; i++) begin
      applyStimulus("run5", seq, 1'b0, 0, 1'b0);
      seq++;
    end

    // Zero is clamped up to one.
    applyStimulus("load0", seq, 1'b1, 0, 1'b0);
    seq++;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("run1", seq, 1'b0, 0, 1'b0);
      seq++;
    end

    // Two back-to-back loads of 4: fill restarts on the second one.
    applyStimulus("load4a", seq, 1'b1, 4, 1'b0);
    seq++;
    applyStimulus("load4b", seq, 1'b1, 4, 1'b0);
    seq++;
    for (int i = 0; i < 7; i++) begin
      applyStimulus("run4", seq, 1'b0, 0, 1'b0);
      seq++;
    end

    // Oversized request clamps to MAX_DELAY; run long enough to wrap twice.
    applyStimulus("load100", seq, 1'b1, 100, 1'b0);
    seq++;
    for (int i = 0; i < 140; i++) begin
      applyStimulus("run64", seq, 1'b0, 0, 1'b0);
      seq++;
    end

`ifdef SM_TIMER_FLUSH_EN
    // Flush at delay 3 keeps the delay; flush with a load takes the load.
    applyStimulus("load3", seq, 1'b1, 3, 1'b0);
    seq++;
    for (int i = 0; i < 5; i++) begin
      applyStimulus("run3", seq, 1'b0, 0, 1'b0);
      seq++;
    end
    applyStimulus("flush", seq, 1'b0, 0, 1'b1);
    seq++;
    for (int i = 0; i < 5; i++) begin
      applyStimulus("refill3", seq, 1'b0, 0, 1'b0);
      seq++;
    end
    applyStimulus("flush_load7", seq, 1'b1, 7, 1'b1);
    seq++;
    for (int i = 0; i < 9; i++) begin
      applyStimulus("run7", seq, 1'b0, 0, 1'b0);
      seq++;
    end
`endif

    // Delay 10, reach RUN, then pulse reset between edges.
    applyStimulus("load10", seq, 1'b1, 10, 1'b0);
    seq++;
    for (int i = 0; i < 14; i++) begin
      applyStimulus("run10", seq, 1'b0, 0, 1'b0);
      seq++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst.dout",    32'(dout),       32'd0);
    checkOutput("arst.valid",   32'(dout_valid), 32'd0);
    checkOutput("arst.dly_cur", 32'(dly_cur),    32'(RESET_DELAY));
    #1;
    rst_n = 1'b1;
    modelReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus("post_rst", seq, 1'b0, 0, 1'b0);
      seq++;
    end

    // Random data with occasional random delay loads.
    for (int i = 0; i < 60; i++) begin
      logic wr;
      wr = ($urandom_range(0, 9) == 0);
      applyStimulus("rand", WIDTH'($urandom), wr,
                    int'($urandom_range(0, 80)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
